sim_run_ctrl: RTL and testbench
===============================

Name: sim_run_ctrl

Overview:
- Run sequencer for the simulation top. Holds the SimTop DUT in reset, then runs a one-time init handshake with the difftest checker, then drives a per-cycle step handshake with that checker.
- Also gates log output to the configured cycle window and buffers DUT UART output towards a host sink.
- Ends the run with a sticky finish flag and a reason code.
- Replaces ad-hoc testbench glue with a synthesizable, verifiable controller.

Parameters:
- RESET_CYCLES, 50: number of cycles dut_reset is held after controller reset deasserts.
- CYC_W, 64: width of the cycle counter and the log/limit config.
- UART_DEPTH, 16: UART buffer entries; power of two, minimum 2.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-low. reset=0 resets the block.
- cfg_log_begin  in  CYC_W  first cycle with logging enabled.
- cfg_log_end  in  CYC_W  first cycle with logging disabled again.
- cfg_max_cycles  in  CYC_W  run limit; 0 means unlimited.
- host_stop  in  1  request to end the run.
- dut_reset  out  1  active-high reset to SimTop.
- log_enable  out  1  logging window active.
- init_req  out  1  init request to the checker.
- init_ack  in  1  checker init done.
- step_req  out  1  step request for the current cycle.
- step_ack  in  1  checker step done.
- step_fail  in  1  qualified by step_ack; 1 = mismatch or trap.
- uart_in_valid  in  1  DUT UART out valid.
- uart_in_ch  in  8  DUT UART out character.
- uart_out_valid  out  1  buffered character available to the host.
- uart_out_ch  out  8  buffered character to the host.
- uart_out_ready  in  1  host sink accepts the character.
- uart_overflow  out  1  sticky: a character was dropped.
- cycle_cnt  out  CYC_W  RUN cycles completed.
- finish  out  1  sticky: run finished.
- finish_code  out  2  reason: 0 none, 1 FAIL, 2 TIMEOUT, 3 STOP.

Behaviour:
Reset values (reset=0):
- state=RESET_HOLD, dut_reset=1, counters=0, FIFO empty.
- init_req=0, step_req=0, uart_out_valid=0, uart_overflow=0.
- finish=0, finish_code=0, log_enable=0.
- Reset mid-run aborts immediately to these values; no drain.

FSM states: RESET_HOLD, INIT, RUN, DRAIN, DONE.
- RESET_HOLD: hold counter increments each cycle.
  - After RESET_CYCLES cycles in the state, go to INIT.
  - dut_reset is registered and drops on the same edge the state enters INIT.
- INIT: init_req=1 (registered level).
  - On the init_ack cycle, go to RUN; init_req drops the next cycle.
  - init_ack outside INIT is ignored.
- RUN: step_req=1 continuously.
  - Each cycle with step_ack=1 and step_fail=0: cycle_cnt += 1, wrapping modulo 2^CYC_W.
  - step_ack=1, step_fail=1: go to DRAIN, code FAIL; cycle_cnt not incremented.
  - cfg_max_cycles!=0 and cycle_cnt+1 == cfg_max_cycles on a successful step: increment, then go to DRAIN, code TIMEOUT.
  - host_stop=1: go to DRAIN, code STOP.
  - Priority when events coincide: FAIL > TIMEOUT > STOP.
  - step_req drops on entering DRAIN.
- DRAIN: wait until the FIFO is empty, then go to DONE.
- DONE: finish=1, finish_code held. Terminal until reset.

log_enable:
- Registered. Equals (cycle_cnt >= cfg_log_begin) && (cycle_cnt < cfg_log_end), evaluated on the updated count, and only while in RUN.
- end <= begin gives logging never enabled.

UART FIFO:
- Push when uart_in_valid && !dut_reset, in any state.
- Pop when uart_out_valid && uart_out_ready.
- Push and pop in the same cycle, including when full: both occur, no drop.
- Push while full without a pop: character dropped, uart_overflow=1 (sticky).
- uart_out_ch is stable while valid && !ready. First-word latency is 1 cycle.

Decomposition:
- Package sim_ctrl_pkg holds:
  - state enum: RESET_HOLD, INIT, RUN, DRAIN, DONE.
  - finish_code enum: NONE=0, FAIL=1, TIMEOUT=2, STOP=3.
- One sub-module: sim_uart_fifo, a synchronous FIFO of UART_DEPTH x 8 with push/pop/full/empty and same-cycle push-pop when full.

Test Plan:
- Reset deasserted at cycle 0, RESET_CYCLES=50 -> dut_reset high for exactly 50 cycles; init_req rises on cycle 50; init_ack at cycle 53 -> step_req=1 from cycle 54.
- cfg_max_cycles=10, all steps ack/pass -> cycle_cnt=10, finish=1, finish_code=2, step_req low after the 10th ack.
- step_fail with ack at step 7 while host_stop=1 in the same cycle -> finish_code=1, cycle_cnt=6.
- cfg_log_begin=3, cfg_log_end=5, unlimited run -> log_enable high only while cycle_cnt is 3 or 4.
- UART_DEPTH=16, push 20 chars with uart_out_ready=0, then ready=1 -> first 16 chars emitted in order, uart_overflow=1. With a FAIL raised meanwhile, finish asserts only after the last pop.
- Controller reset pulsed during RUN with FIFO non-empty -> all outputs at reset values the next cycle, FIFO empty, dut_reset=1.

Source files
------------

// File: rtl/sim_ctrl_pkg.sv
// Shared state encodings and finish reasons for the simulation run controller.
package sim_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StResetHold = 3'd0;
  localparam state_t StInit      = 3'd1;
  localparam state_t StRun       = 3'd2;
  localparam state_t StDrain     = 3'd3;
  localparam state_t StDone      = 3'd4;

  typedef enum logic [1:0] {
    CodeNone    = 2'd0,
    CodeFail    = 2'd1,
    CodeTimeout = 2'd2,
    CodeStop    = 2'd3
  } finish_code_e;

endpackage

// File: rtl/sim_uart_fifo.sv
// Synchronous FIFO for DUT UART characters; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sim_uart_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == FullCnt);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rptr_q];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr_q] <= push_data;
  end

endmodule

// File: rtl/sim_run_ctrl.sv
// Run sequencer: holds SimTop in reset, does the checker init and per-cycle
// step handshakes, gates logging and buffers UART output to the host.
module sim_run_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 50,
  parameter int unsigned CYC_W        = 64,
  parameter int unsigned UART_DEPTH   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CYC_W-1:0] cfg_log_begin,
  input  logic [CYC_W-1:0] cfg_log_end,
  input  logic [CYC_W-1:0] cfg_max_cycles,
  input  logic             host_stop,
  output logic             dut_reset,
  output logic             log_enable,
  output logic             init_req,
  input  logic             init_ack,
  output logic             step_req,
  input  logic             step_ack,
  input  logic             step_fail,
  input  logic             uart_in_valid,
  input  logic [7:0]       uart_in_ch,
  output logic             uart_out_valid,
  output logic [7:0]       uart_out_ch,
  input  logic             uart_out_ready,
  output logic             uart_overflow,
  output logic [CYC_W-1:0] cycle_cnt,
  output logic             finish,
  output logic [1:0]       finish_code
);

  state_t           state_q, state_d;
  logic [31:0]      hold_q, hold_d;
  logic [CYC_W-1:0] cnt_q, cnt_d, cnt_inc;
  finish_code_e     code_q, code_d, finish_code_q;
  logic             dut_reset_q, init_req_q, step_req_q, log_q, ovf_q, finish_q;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty, step_ok;

  assign cnt_inc = cnt_q + 1'b1;
  assign step_ok = step_ack && !step_fail;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    case (state_q)
      StResetHold: begin
        if (hold_q + 32'd1 >= RESET_CYCLES) state_d = StInit;
        else hold_d = hold_q + 32'd1;
      end
      StInit: begin
        if (init_ack) state_d = StRun;
      end
      StRun: begin
        if (step_ack && step_fail) begin
          state_d = StDrain;
          code_d  = CodeFail;
        end else begin
          if (step_ok) cnt_d = cnt_inc;
          if (step_ok && (cfg_max_cycles != '0) && (cnt_inc == cfg_max_cycles)) begin
            state_d = StDrain;
            code_d  = CodeTimeout;
          end else if (host_stop) begin
            state_d = StDrain;
            code_d  = CodeStop;
          end
        end
      end
      StDrain: begin
        if (fifo_empty) state_d = StDone;
      end
      StDone:  state_d = StDone;
      default: state_d = StResetHold;
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state itself.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= StResetHold;
      hold_q        <= '0;
      cnt_q         <= '0;
      code_q        <= CodeNone;
      dut_reset_q   <= 1'b1;
      init_req_q    <= 1'b0;
      step_req_q    <= 1'b0;
      log_q         <= 1'b0;
      ovf_q         <= 1'b0;
      finish_q      <= 1'b0;
      finish_code_q <= CodeNone;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      cnt_q         <= cnt_d;
      code_q        <= code_d;
      dut_reset_q   <= (state_d == StResetHold);
      init_req_q    <= (state_d == StInit);
      step_req_q    <= (state_d == StRun);
      log_q         <= (state_d == StRun) && (cnt_d >= cfg_log_begin) && (cnt_d < cfg_log_end);
      finish_q      <= (state_d == StDone);
      finish_code_q <= (state_d == StDone) ? code_d : CodeNone;
      if (fifo_push && fifo_full && !fifo_pop) ovf_q <= 1'b1;
    end
  end

  assign fifo_push = uart_in_valid && !dut_reset_q;
  assign fifo_pop  = uart_out_valid && uart_out_ready;

  sim_uart_fifo #(
    .DEPTH (UART_DEPTH),
    .WIDTH (8)
  ) u_uart_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (uart_in_ch),
    .pop       (fifo_pop),
    .pop_data  (uart_out_ch),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign uart_out_valid = !fifo_empty;
  assign dut_reset      = dut_reset_q;
  assign init_req       = init_req_q;
  assign step_req       = step_req_q;
  assign log_enable     = log_q;
  assign uart_overflow  = ovf_q;
  assign cycle_cnt      = cnt_q;
  assign finish         = finish_q;
  assign finish_code    = finish_code_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl with hand-computed expectations.
module tb_sim_run_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] cfg_log_begin, cfg_log_end, cfg_max_cycles;
  logic        host_stop, dut_reset, log_enable, init_req, init_ack;
  logic        step_req, step_ack, step_fail;
  logic        uart_in_valid, uart_out_valid, uart_out_ready, uart_overflow;
  logic [7:0]  uart_in_ch, uart_out_ch;
  logic [63:0] cycle_cnt;
  logic        finish;
  logic [1:0]  finish_code;

  int n_checks = 0;
  int n_pass   = 0;

  sim_run_ctrl #(
    .RESET_CYCLES (50),
    .CYC_W        (64),
    .UART_DEPTH   (16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .cfg_log_begin  (cfg_log_begin),
    .cfg_log_end    (cfg_log_end),
    .cfg_max_cycles (cfg_max_cycles),
    .host_stop      (host_stop),
    .dut_reset      (dut_reset),
    .log_enable     (log_enable),
    .init_req       (init_req),
    .init_ack       (init_ack),
    .step_req       (step_req),
    .step_ack       (step_ack),
    .step_fail      (step_fail),
    .uart_in_valid  (uart_in_valid),
    .uart_in_ch     (uart_in_ch),
    .uart_out_valid (uart_out_valid),
    .uart_out_ch    (uart_out_ch),
    .uart_out_ready (uart_out_ready),
    .uart_overflow  (uart_overflow),
    .cycle_cnt      (cycle_cnt),
    .finish         (finish),
    .finish_code    (finish_code)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_dut_reset"}, 64'(dut_reset), 64'd1);
    check_eq({tag, "_init_req"}, 64'(init_req), 64'd0);
    check_eq({tag, "_step_req"}, 64'(step_req), 64'd0);
    check_eq({tag, "_uart_valid"}, 64'(uart_out_valid), 64'd0);
    check_eq({tag, "_overflow"}, 64'(uart_overflow), 64'd0);
    check_eq({tag, "_finish"}, {62'd0, finish, 1'b0} | 64'(finish_code), 64'd0);
    check_eq({tag, "_log"}, 64'(log_enable), 64'd0);
    check_eq({tag, "_cycle_cnt"}, cycle_cnt, 64'd0);
  endtask

  task automatic clear_inputs();
    host_stop = 0; init_ack = 0; step_ack = 0; step_fail = 0;
    uart_in_valid = 0; uart_in_ch = 8'h00; uart_out_ready = 0;
  endtask

  // Reset, release, wait out the hold, ack init: returns in the first RUN cycle.
  task automatic go_run();
    clear_inputs();
    reset = 0;
    tick(); tick();
    reset = 1;
    repeat (50) tick();
    init_ack = 1;
    tick();
    init_ack = 0;
  endtask

  initial begin
    int hi, popped, bad, last_i, fin_i;
    logic [8:0] mask;
    logic [7:0] exp_ch, last_ch, first_ch;

    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi, popped, bad, last_i, fin_i;
    logic [8:0] mask;
    logic [7:0] exp_ch, last_ch, first_ch;

    cfg_log_begin = 0; cfg_log_end = 0; cfg_max_cycles = 0;
    clear_inputs();

    // Reset sequence and init handshake timing.
    reset = 0;
    tick(); tick();
    check_reset_values("rst");
    reset = 1;
    hi = 0;
    for (int i = 0; i < 50; i++) begin
      if (dut_reset) hi++;
      if (i == 49) check_eq("init_req_before_50", 64'(init_req), 64'd0);
      tick();
    end
    check_eq("dut_reset_high_cycles", 64'(hi), 64'd50);
    check_eq("dut_reset_low_at_50", 64'(dut_reset), 64'd0);
    check_eq("init_req_at_50", 64'(init_req), 64'd1);
    repeat (3) tick();
    check_eq("step_req_at_53", 64'(step_req), 64'd0);
    init_ack = 1;
    tick();
    init_ack = 0;
    check_eq("step_req_at_54", 64'(step_req), 64'd1);
    check_eq("init_req_dropped", 64'(init_req), 64'd0);

    // Timeout after 10 passing steps.
    cfg_max_cycles = 10;
    go_run();
    step_ack = 1;
    repeat (9) tick();
    check_eq("to_cnt9", cycle_cnt, 64'd9);
    check_eq("to_step_req9", 64'(step_req), 64'd1);
    tick();
    step_ack = 0;
    check_eq("to_cnt10", cycle_cnt, 64'd10);
    check_eq("to_step_req_low", 64'(step_req), 64'd0);
    tick();
    check_eq("to_finish", 64'(finish), 64'd1);
    check_eq("to_code", 64'(finish_code), 64'd2);
    cfg_max_cycles = 0;

    // Fail at step 7 coinciding with host_stop: FAIL wins, no increment.
    go_run();
    step_ack = 1;
    repeat (6) tick();
    step_fail = 1; host_stop = 1;
    tick();
    step_ack = 0; step_fail = 0; host_stop = 0;
    check_eq("fail_step_req_low", 64'(step_req), 64'd0);
    tick();
    check_eq("fail_finish", 64'(finish), 64'd1);
    check_eq("fail_code", 64'(finish_code), 64'd1);
    check_eq("fail_cnt", cycle_cnt, 64'd6);

    // host_stop alone.
    go_run();
    host_stop = 1;
    tick();
    host_stop = 0;
    tick();
    check_eq("stop_code", 64'(finish_code), 64'd3);
    check_eq("stop_cnt", cycle_cnt, 64'd0);

    // Log window [3,5), then an empty window.
    cfg_log_begin = 3; cfg_log_end = 5;
    go_run();
    step_ack = 1;
    mask = '0;
    mask[0] = log_enable;
    for (int k = 1; k < 9; k++) begin
      tick();
      if (cycle_cnt == 64'(k)) mask[k] = log_enable;
      else mask[k] = 1'bx;
    end
    check_eq("log_window_mask", 64'(mask), 64'h018);
    cfg_log_begin = 10; cfg_log_end = 9;
    hi = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (log_enable) hi++;
    end
    check_eq("log_empty_window", 64'(hi), 64'd0);
    step_ack = 0;
    cfg_log_begin = 0; cfg_log_end = 0;

    // UART overflow, then FAIL while draining.
    go_run();
    for (int i = 0; i < 20; i++) begin
      uart_in_valid = 1;
      uart_in_ch = 8'h41 + 8'(i);
      tick();
      if (i == 0) begin
        check_eq("uart_first_valid", 64'(uart_out_valid), 64'd1);
        check_eq("uart_first_ch", 64'(uart_out_ch), 64'h41);
      end
    end
    uart_in_valid = 0;
    check_eq("uart_hold_ch", 64'(uart_out_ch), 64'h41);
    check_eq("uart_overflow", 64'(uart_overflow), 64'd1);
    step_ack = 1; step_fail = 1;
    tick();
    step_ack = 0; step_fail = 0;
    tick();
    check_eq("drain_no_finish", 64'(finish), 64'd0);
    uart_out_ready = 1;
    popped = 0; bad = 0; last_i = -1; fin_i = -1;
    for (int i = 0; i < 40; i++) begin
      if (finish && fin_i < 0) fin_i = i;
      if (uart_out_valid) begin
        exp_ch = 8'h41 + 8'(popped);
        if (uart_out_ch !== exp_ch) bad++;
        popped++;
        last_i = i;
      end
      tick();
    end
    check_eq("drain_popped", 64'(popped), 64'd16);
    check_eq("drain_order_errors", 64'(bad), 64'd0);
    check_eq("finish_after_last_pop", 64'(fin_i - last_i), 64'd2);
    check_eq("drain_code", 64'(finish_code), 64'd1);

    // Push and pop in the same cycle while full.
    go_run();
    for (int i = 0; i < 16; i++) begin
      uart_in_valid = 1;
      uart_in_ch = 8'h41 + 8'(i);
      tick();
    end
    uart_in_ch = 8'h51; uart_out_ready = 1;
    tick();
    uart_in_valid = 0;
    check_eq("full_pushpop_no_ovf", 64'(uart_overflow), 64'd0);
    popped = 0; first_ch = 8'h00; last_ch = 8'h00;
    for (int i = 0; i < 20; i++) begin
      if (uart_out_valid) begin
        if (popped == 0) first_ch = uart_out_ch;
        last_ch = uart_out_ch;
        popped++;
      end
      tick();
    end
    check_eq("full_pushpop_count", 64'(popped), 64'd16);
    check_eq("full_pushpop_first", 64'(first_ch), 64'h42);
    check_eq("full_pushpop_last", 64'(last_ch), 64'h51);

    // Controller reset mid-run with a non-empty FIFO.
    go_run();
    step_ack = 1;
    repeat (3) tick();
    step_ack = 0;
    for (int i = 0; i < 3; i++) begin
      uart_in_valid = 1;
      uart_in_ch = 8'h61 + 8'(i);
      tick();
    end
    uart_in_valid = 0;
    check_eq("midrun_pre_valid", 64'(uart_out_valid), 64'd1);
    check_eq("midrun_pre_cnt", cycle_cnt, 64'd3);
    reset = 0;
    tick();
    check_reset_values("midrun");
    reset = 1;
    tick();
    check_eq("midrun_fifo_empty", 64'(uart_out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
